// File: rtl/power_trigger_hyst.sv
// Packet power trigger: |I|+|Q| magnitude, 2^LOG2_WIN moving average, hysteretic trigger FSM.
// Optional macro POWER_TRIGGER_PEAK_EN adds a per-packet peak_level output.
module power_trigger_hyst #(
    parameter int IQ_WIDTH  = 16,
    parameter int LOG2_WIN  = 4,
    parameter int ADDR_HI   = 3,
    parameter int ADDR_LO   = 4,
    parameter int ADDR_HOLD = 5,
    parameter int ADDR_SKIP = 6
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    set_stb,
    input  logic [7:0]              set_addr,
    input  logic [31:0]             set_data,
    input  logic [2*IQ_WIDTH-1:0]   sample_in,
    input  logic                    sample_in_strobe,
    output logic                    trigger,
    output logic                    trigger_start,
    output logic [IQ_WIDTH:0]       power_level
`ifdef POWER_TRIGGER_PEAK_EN
    ,
    output logic [IQ_WIDTH:0]       peak_level
`endif
);

    localparam int M   = IQ_WIDTH + 1;
    localparam int WIN = 1 << LOG2_WIN;
    localparam int SW  = M + LOG2_WIN;

    localparam logic [7:0] L_ADDR_HI   = 8'(ADDR_HI);
    localparam logic [7:0] L_ADDR_LO   = 8'(ADDR_LO);
    localparam logic [7:0] L_ADDR_HOLD = 8'(ADDR_HOLD);
    localparam logic [7:0] L_ADDR_SKIP = 8'(ADDR_SKIP);

    typedef enum logic [1:0] {
        S_SKIP   = 2'd0,
        S_IDLE   = 2'd1,
        S_PACKET = 2'd2
    } state_t;

    logic [M-1:0]  r_hi;
    logic [M-1:0]  r_lo;
    logic [15:0]   r_hold;
    logic [31:0]   r_skip;

    logic          w_adv;
    logic          w_skip_changed;

    assign w_adv          = enable & sample_in_strobe;
    assign w_skip_changed = enable & set_stb & (set_addr == L_ADDR_SKIP);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_hi   <= M'(100);
            r_lo   <= M'(60);
            r_hold <= 16'd80;
            r_skip <= 32'd5000000;
        end else if (enable && set_stb) begin
            if (set_addr == L_ADDR_HI)   r_hi   <= set_data[M-1:0];
            if (set_addr == L_ADDR_LO)   r_lo   <= set_data[M-1:0];
            if (set_addr == L_ADDR_HOLD) r_hold <= set_data[15:0];
            if (set_addr == L_ADDR_SKIP) r_skip <= set_data;
        end
    end

    // Sign-extend by one bit so abs(most-negative) is representable.
    logic [M-1:0] w_i_ext, w_q_ext, w_abs_i, w_abs_q;

    assign w_i_ext = {sample_in[2*IQ_WIDTH-1], sample_in[2*IQ_WIDTH-1:IQ_WIDTH]};
    assign w_q_ext = {sample_in[IQ_WIDTH-1],   sample_in[IQ_WIDTH-1:0]};
    assign w_abs_i = w_i_ext[M-1] ? (~w_i_ext + M'(1)) : w_i_ext;
    assign w_abs_q = w_q_ext[M-1] ? (~w_q_ext + M'(1)) : w_q_ext;

    logic [M-1:0]  r_mag;
    logic [M-1:0]  r_win [WIN];
    logic [SW-1:0] r_sum;
    logic [M-1:0]  w_power;

    // NOTE: the window array is reset explicitly because the running sum assumes it starts at zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_mag <= '0;
            r_sum <= '0;
            for (int k = 0; k < WIN; k++) r_win[k] <= '0;
        end else if (w_adv) begin
            r_mag    <= w_abs_i + w_abs_q;
            r_sum    <= r_sum + SW'(r_mag) - SW'(r_win[WIN-1]);
            r_win[0] <= r_mag;
            for (int k = 1; k < WIN; k++) r_win[k] <= r_win[k-1];
        end
    end

    assign w_power     = r_sum[SW-1:LOG2_WIN];
    assign power_level = w_power;

    state_t        r_state, w_state_next;
    logic [31:0]   r_count, w_count_next;
    logic          r_trigger, w_trigger_next;
    logic          r_trigger_start, w_start_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state         <= S_SKIP;
            r_count         <= '0;
            r_trigger       <= 1'b0;
            r_trigger_start <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_count         <= w_count_next;
            r_trigger       <= w_trigger_next;
            r_trigger_start <= w_start_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next   = r_state;
        w_count_next   = r_count;
        w_trigger_next = r_trigger;
        w_start_next   = 1'b0;

        if (w_skip_changed && (r_state != S_SKIP)) begin
            w_state_next   = S_SKIP;
            w_count_next   = '0;
            w_trigger_next = 1'b0;
        end else if (w_adv) begin
            unique case (r_state)
                S_SKIP: begin
                    if (r_count >= r_skip) begin
                        w_state_next = S_IDLE;
                        w_count_next = '0;
                    end else begin
                        w_count_next = r_count + 32'd1;
                    end
                end
                S_IDLE: begin
                    if (w_power > r_hi) begin
                        w_state_next   = S_PACKET;
                        w_trigger_next = 1'b1;
                        w_start_next   = 1'b1;
                        w_count_next   = '0;
                    end
                end
                S_PACKET: begin
                    if (w_power < r_lo) begin
                        if (r_count >= {16'd0, r_hold}) begin
                            w_state_next   = S_IDLE;
                            w_trigger_next = 1'b0;
                        end else begin
                            w_count_next = r_count + 32'd1;
                        end
                    end else begin
                        w_count_next = '0;
                    end
                end
                default: begin
                    w_state_next   = S_SKIP;
                    w_count_next   = '0;
                    w_trigger_next = 1'b0;
                end
            endcase
        end
    end

    assign trigger       = r_trigger;
    assign trigger_start = r_trigger_start;

`ifdef POWER_TRIGGER_PEAK_EN
    logic [M-1:0] r_peak;

    // Restart at the entry level, then track the maximum while the packet lasts.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_peak <= '0;
        end else if (w_start_next) begin
            r_peak <= w_power;
        end else if (w_adv && !w_skip_changed && (r_state == S_PACKET) && (w_power > r_peak)) begin
            r_peak <= w_power;
        end
    end

    assign peak_level = r_peak;
`endif

endmodule
